// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the Data_Mem arbiter: FSM states, owner IDs and stats width.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_L = 1'b1
  } owner_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter for the loader port; hit_o flags that the loader has waited MAX_WAIT cycles.
module starve_counter #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port Data_Mem arbiter (core C over loader L, with a starvation guard for L).
// Define DMEM_ARB_STATS_EN to add grant/conflict statistics outputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] c_grants,
  output logic [STATS_W-1:0] l_grants,
  output logic [STATS_W-1:0] conflicts
`endif
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic              grant_c, grant_l;
  logic              wait_hit;
  logic              wait_inc, wait_clr;

  // L's own transaction does not count as waiting.
  assign wait_inc = l_req && !((owner_q == OWN_L) && (state_q != ST_IDLE));
  assign wait_clr = !l_req || grant_l;

  starve_counter #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc_i(wait_inc),
    .clr_i(wait_clr),
    .hit_o(wait_hit)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    grant_c   = 1'b0;
    grant_l   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (l_req && wait_hit) begin
          grant_l = 1'b1;
        end else if (c_req) begin
          grant_c = 1'b1;
        end else if (l_req) begin
          grant_l = 1'b1;
        end
        if (grant_c) begin
          owner_d = OWN_C;
          we_d    = c_we;
          addr_d  = c_addr;
          wdata_d = c_wdata;
          state_d = ST_ISSUE;
        end else if (grant_l) begin
          owner_d = OWN_L;
          we_d    = l_we;
          addr_d  = l_addr;
          wdata_d = l_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!we_q) begin
          if (owner_q == OWN_C) c_rdata_d = mem_rdata;
          else                  l_rdata_d = mem_rdata;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_C;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  // Strobes decode straight from state_q so reset drops them asynchronously.
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c_ack     = (state_q == ST_ACK) && (owner_q == OWN_C);
  assign l_ack     = (state_q == ST_ACK) && (owner_q == OWN_L);
  assign c_rdata   = c_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign c_stall   = c_req && (owner_q == OWN_L);

`ifdef DMEM_ARB_STATS_EN
  logic [STATS_W-1:0] c_grants_q, l_grants_q, conflicts_q;
  logic               conflict_cyc;

  assign conflict_cyc = (state_q == ST_IDLE) && c_req && l_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_grants_q  <= '0;
      l_grants_q  <= '0;
      conflicts_q <= '0;
    end else begin
      if (grant_c && (c_grants_q != '1))       c_grants_q  <= c_grants_q + STATS_W'(1);
      if (grant_l && (l_grants_q != '1))       l_grants_q  <= l_grants_q + STATS_W'(1);
      if (conflict_cyc && (conflicts_q != '1)) conflicts_q <= conflicts_q + STATS_W'(1);
    end
  end

  assign c_grants  = c_grants_q;
  assign l_grants  = l_grants_q;
  assign conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; stats checks compile in with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic        c_ack, c_stall;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        l_ack;
  logic [31:0] l_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] c_grants, l_grants, conflicts;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8), .WAIT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_ack    (c_ack),
    .c_rdata  (c_rdata),
    .c_stall  (c_stall),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_ack    (l_ack),
    .l_rdata  (l_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .c_grants (c_grants),
    .l_grants (l_grants),
    .conflicts(conflicts)
`endif
  );

  // Called at a negedge; returns at the negedge where ack is seen (lat = negedges waited, -1 on timeout).
  task automatic run_c(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int wcnt);
    c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1;
    lat = -1; wcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_en && mem_we) wcnt++;
      if (c_ack) begin lat = i; break; end
    end
    c_req = 1'b0;
  endtask

  task automatic run_l(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int stall_seen);
    l_we = we; l_addr = a; l_wdata = d; l_req = 1'b1;
    lat = -1; stall_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (c_stall) stall_seen++;
      if (l_ack) begin lat = i; break; end
    end
    l_req = 1'b0;
  endtask

  task automatic test_reset();
    mem[8'h40] = 32'hA5A5_0040;
    reset = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    repeat (3) @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if ({c_ack, l_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {c_ack, l_ack}); end
    checks++; if (c_rdata !== 32'h0 || l_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", c_rdata, l_rdata); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL reset_release_issue: got en=%b addr=%h expected en=1 addr=40", mem_en, mem_addr); end
    @(negedge clk);
    checks++; if (c_ack !== 1'b1 || c_rdata !== 32'hA5A5_0040) begin errors++; $display("FAIL reset_release_ack: got ack=%b rdata=%h expected ack=1 rdata=a5a50040", c_ack, c_rdata); end
    c_req = 1'b0;
    @(negedge clk);
    checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", c_ack); end
  endtask

  task automatic test_c_write_read();
    int lat, wcnt;
    run_c(1'b1, 32'h10, 32'hDEAD_BEEF, lat, wcnt);
    checks++; if (lat != 2) begin errors++; $display("FAIL c_write_latency: got %0d expected 2", lat); end
    checks++; if (wcnt != 1) begin errors++; $display("FAIL c_write_strobes: got %0d expected 1", wcnt); end
    checks++; if (mem[8'h10] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL c_write_mem: got %h expected deadbeef", mem[8'h10]); end
    @(negedge clk);
    run_c(1'b0, 32'h10, 32'h0, lat, wcnt);
    checks++; if (lat != 2) begin errors++; $display("FAIL c_read_latency: got %0d expected 2", lat); end
    checks++; if (wcnt != 0) begin errors++; $display("FAIL c_read_strobes: got %0d expected 0", wcnt); end
    checks++; if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL c_read_data: got %h expected deadbeef", c_rdata); end
    @(negedge clk);
    checks++; if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL c_rdata_hold: got %h expected deadbeef", c_rdata); end
  endtask

  task automatic test_l_read();
    int lat, stall_seen;
    mem[8'h20] = 32'h0000_1234;
    @(negedge clk);
    run_l(1'b0, 32'h20, 32'h0, lat, stall_seen);
    checks++; if (lat != 2) begin errors++; $display("FAIL l_read_latency: got %0d expected 2", lat); end
    checks++; if (l_rdata !== 32'h0000_1234) begin errors++; $display("FAIL l_read_data: got %h expected 00001234", l_rdata); end
    checks++; if (stall_seen != 0) begin errors++; $display("FAIL l_read_c_stall: got %0d stall cycles expected 0", stall_seen); end
    checks++; if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL l_read_c_rdata: got %h expected deadbeef", c_rdata); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic exp_seq [8];
    logic got_seq [8];
    int n;
    int bad_stall;
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    n = 0; bad_stall = 0;
    c_we = 1'b0; c_addr = 32'h10; c_req = 1'b1;
    l_we = 1'b0; l_addr = 32'h20; l_req = 1'b1;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk);
      if (c_ack && l_ack) bad_stall++;
      else if (c_ack) begin
        if (c_stall !== 1'b0) bad_stall++;
        got_seq[n] = 1'b0; n++;
      end else if (l_ack) begin
        if (c_stall !== 1'b1) bad_stall++;
        got_seq[n] = 1'b1; n++;
      end
    end
    c_req = 1'b0; l_req = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL starve_ack_count: got %0d expected 8", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_seq[k] !== exp_seq[k]) begin errors++; $display("FAIL starve_order[%0d]: got owner %b expected %b", k, got_seq[k], exp_seq[k]); end
    end
    checks++; if (bad_stall != 0) begin errors++; $display("FAIL starve_stall: got %0d bad cycles expected 0", bad_stall); end
    checks++; if (l_rdata !== 32'h0000_1234 || c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL starve_rdata: got %h/%h expected 00001234/deadbeef", l_rdata, c_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ack_seen, en_seen;
    mem[8'h30] = 32'h5555_5555;
    c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hCAFE_F00D; c_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL midrst_issue: got en=%b we=%b expected 1/1", mem_en, mem_we); end
    #1 reset = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midrst_async_en: got en=%b we=%b expected 0/0", mem_en, mem_we); end
    c_req = 1'b0;
    @(negedge clk);
    checks++; if (mem[8'h30] !== 32'h5555_5555) begin errors++; $display("FAIL midrst_no_commit: got %h expected 55555555", mem[8'h30]); end
    reset = 1'b1;
    ack_seen = 0; en_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (c_ack) ack_seen++;
      if (mem_en) en_seen++;
    end
    checks++; if (ack_seen != 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks expected 0", ack_seen); end
    checks++; if (en_seen != 0 || mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_idle: got en_cycles=%0d addr=%h expected 0/0", en_seen, mem_addr); end
    checks++; if (mem[8'h30] !== 32'h5555_5555) begin errors++; $display("FAIL midrst_mem_after: got %h expected 55555555", mem[8'h30]); end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    int lat, wcnt;
    checks++; if ({c_grants, l_grants, conflicts} !== 48'h0) begin errors++; $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", c_grants, l_grants, conflicts); end
    c_we = 1'b0; c_addr = 32'h10; l_we = 1'b0; l_addr = 32'h20;
    repeat (2) begin
      c_req = 1'b1; l_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (c_ack) c_req = 1'b0;
        if (l_ack) break;
      end
      c_req = 1'b0; l_req = 1'b0;
      @(negedge clk);
    end
    c_req = 1'b1; l_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_ack) break;
    end
    c_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    run_c(1'b0, 32'h10, 32'h0, lat, wcnt);
    @(negedge clk);
    run_c(1'b0, 32'h10, 32'h0, lat, wcnt);
    @(negedge clk);
    checks++; if (c_grants !== 16'd5) begin errors++; $display("FAIL stats_c_grants: got %0d expected 5", c_grants); end
    checks++; if (l_grants !== 16'd2) begin errors++; $display("FAIL stats_l_grants: got %0d expected 2", l_grants); end
    checks++; if (conflicts !== 16'd3) begin errors++; $display("FAIL stats_conflicts: got %0d expected 3", conflicts); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_c_write_read();
    test_l_read();
    test_starvation();
    test_reset_mid();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
